// File: rtl/rr_grant_encoder_pkg.sv
// ============================================================================
// Module : arb_pkg
// Shared sizing defaults and types for the round-robin grant encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;
    localparam int N_REQ    = 8;
    localparam int IDX_W    = $clog2(N_REQ);
    localparam int HOLD_MAX = 16;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

`default_nettype wire

// File: rtl/rr_grant_encoder_if.sv
// ============================================================================
// Module : rr_grant_encoder_if
// Request/grant bundle between the requesters and the round-robin encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_grant_encoder_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    idx_t             gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt_idx, gnt_valid, timeout
    );
endinterface

`default_nettype wire

// File: rtl/rr_grant_encoder_pick.sv
// ============================================================================
// Module : rr_pick
// Combinational round-robin winner search: rotate by ptr, find lowest, unrotate.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = arb_pkg::N_REQ,
    parameter int IDX_W = arb_pkg::IDX_W
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic                  any,
    output logic [IDX_W-1:0]      idx
);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;

    // N_REQ is a power of two, so the index add wraps naturally in IDX_W bits.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = w_off + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_grant_encoder.sv
// ============================================================================
// Module : rr_grant_encoder
// 8-way round-robin arbiter with registered grant index and hold watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_encoder #(
    parameter int N_REQ    = arb_pkg::N_REQ,
    parameter int IDX_W    = arb_pkg::IDX_W,
    parameter int HOLD_MAX = arb_pkg::HOLD_MAX
) (
    input wire logic         clk,
    input wire logic         rst,
    rr_grant_encoder_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_pkg::arb_state_t r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic                r_gnt_valid;
    logic                r_timeout;

    logic                w_any;
    logic [IDX_W-1:0]    w_win;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= arb_pkg::IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                arb_pkg::IDLE: begin
                    if (w_any) begin
                        r_gnt_idx   <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= arb_pkg::GRANT;
                    end
                end
                arb_pkg::GRANT: begin
                    // done takes precedence over a simultaneous watchdog expiry.
                    if (bus.done) begin
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_idx + 1'b1;
                        r_state     <= arb_pkg::IDLE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_ptr       <= r_gnt_idx + 1'b1;
                        r_state     <= arb_pkg::IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= arb_pkg::IDLE;
            endcase
        end
    end

    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
// ============================================================================
// Module : tb_rr_grant_encoder
// Directed self-checking bench for the round-robin grant encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rr_grant_encoder_if bus ();

    rr_grant_encoder #(
        .N_REQ    (8),
        .IDX_W    (3),
        .HOLD_MAX (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a grant on the next edge, then release it with a one-cycle done.
    task automatic grant_release(input logic [2:0] exp_idx);
        tick();
        check_eq("grant_valid", 32'(bus.gnt_valid), 32'd1);
        check_eq("grant_idx", 32'(bus.gnt_idx), 32'(exp_idx));
        bus.done = 1'b1;
        tick();
        check_eq("release_valid", 32'(bus.gnt_valid), 32'd0);
        bus.done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("idle_valid", 32'(bus.gnt_valid), 32'd0);
            check_eq("idle_idx", 32'(bus.gnt_idx), 32'd0);
            check_eq("idle_timeout", 32'(bus.timeout), 32'd0);
        end

        // Sparse request pattern: 2, 5, 7, wrap to 2.
        bus.req = 8'b1010_0100;
        grant_release(3'd2);
        grant_release(3'd5);
        grant_release(3'd7);
        grant_release(3'd2);
        bus.req = 8'h00;

        // Full request vector from a fresh reset: 0..7 then 0.
        rst = 1'b1;
        tick();
        check_eq("rst_valid", 32'(bus.gnt_valid), 32'd0);
        rst     = 1'b0;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            grant_release(3'(i));
        end
        // ptr is now 1.

        // Watchdog: grant idx 3 held with no done.
        bus.req = 8'h08;
        tick();
        check_eq("wd_grant_idx", 32'(bus.gnt_idx), 32'd3);
        check_eq("wd_grant_valid", 32'(bus.gnt_valid), 32'd1);
        bus.req = 8'h09;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("wd_hold_valid", 32'(bus.gnt_valid), 32'd1);
            check_eq("wd_hold_timeout", 32'(bus.timeout), 32'd0);
        end
        tick();
        check_eq("wd_revoke_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("wd_timeout_pulse", 32'(bus.timeout), 32'd1);
        tick();
        check_eq("wd_next_idx", 32'(bus.gnt_idx), 32'd0);
        check_eq("wd_next_valid", 32'(bus.gnt_valid), 32'd1);
        check_eq("wd_timeout_clear", 32'(bus.timeout), 32'd0);

        // done on the last watchdog cycle wins over expiry.
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check_eq("late_done_pre_valid", 32'(bus.gnt_valid), 32'd1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_eq("late_done_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("late_done_timeout", 32'(bus.timeout), 32'd0);
        grant_release(3'd3);
        // ptr is now 4.

        // Reset in the middle of a grant at idx 6.
        bus.req = 8'h40;
        tick();
        check_eq("mid_grant_idx", 32'(bus.gnt_idx), 32'd6);
        bus.req = 8'h41;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("mid_rst_idx", 32'(bus.gnt_idx), 32'd0);
        check_eq("mid_rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_idx", 32'(bus.gnt_idx), 32'd0);
        check_eq("post_rst_valid", 32'(bus.gnt_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
